loop_nest_counter: RTL and testbench
====================================

# loop_nest_counter

Parametrised nested-loop index generator for the GNN datapath: NUM_LEVELS cascaded wrap counters with runtime-loadable per-level bounds, start/done control and a valid/ready output handshake. Sits between the layer controller and the feature/adjacency address generators, emitting one index tuple per accepted beat (e.g. node × feature-tile × channel). Supersedes fixed-bound single-level counters where iteration limits depend on the layer being processed.

## Interface
- NUM_LEVELS, 3: number of nested levels; level 0 is innermost (fastest).
- CNT_W, 8: width of each level's index and bound.

- clk  input  1  clock.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  pulse; launches a run when not busy.
- abort  input  1  synchronous cancel of a run in progress.
- bound  input  NUM_LEVELS×CNT_W  per-level last index (inclusive), sampled on accepted start.
- idx_ready  input  1  downstream accepts current tuple.
- idx  output  NUM_LEVELS×CNT_W  current index tuple.
- idx_valid  output  1  idx is a valid beat.
- wrap  output  NUM_LEVELS  wrap[k]=1: accepting this beat wraps level k.
- last  output  1  current beat is the final beat of the run.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse after final beat accepted.

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE; all outputs 0, idx all zeros, bound registers 0.
- IDLE/DONE: start=1 and abort=0 → latch bound, clear idx, go RUN. start in RUN ignored.
- RUN: busy=1, idx_valid=1. Beat accepted when idx_valid && idx_ready; otherwise idx, wrap and last hold.
- On acceptance: level 0 increments; level k (k>0) increments only when every level j<k is at its latched bound. Level at bound with carry-in wraps to 0.
- wrap[k] = idx_valid && (idx[j]==bound[j] for all j≤k). last = &wrap.
- Accepted beat with last=1 → DONE: idx_valid=0, busy=0, done=1 for exactly one cycle, idx reset to 0, then IDLE unless start.
- Bound 0 on a level: that level holds 0 and passes carry every beat. All bounds 0: run is exactly one beat.
- Total beats per run = product of (bound[k]+1); counting arithmetic is unsigned CNT_W with no overflow (index never exceeds bound).
- bound input changes during RUN have no effect.
- abort=1 in RUN: next cycle IDLE, idx_valid=0, idx=0, no done pulse. abort has priority over acceptance and start in the same cycle. abort in IDLE/DONE has no effect except suppressing start.
- reset mid-run: immediate return to reset values; no done.

## Timing
- start→first idx_valid: 1 cycle (registered).
- Throughput: one beat per cycle with idx_ready held high; no bubbles across level wraps.
- Final acceptance (cycle N) → done=1 in cycle N+1; earliest next start accepted in cycle N+1, first beat of new run in N+2.
- wrap/last are combinational from registered state only; no combinational path from idx_ready to any output.

## Configuration
- LOOP_NEST_STALL_CNT_EN defined: adds output stall_cnt (32 bits), counting cycles in RUN with idx_valid=1 and idx_ready=0; cleared on accepted start and on reset, saturates at all-ones, holds after DONE/abort.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package gnn_cnt_pkg: state enum (IDLE, RUN, DONE), typedef for a CNT_W index vector, stall-counter width constant.
- One sub-module loop_level: single-level counter with runtime bound, load-clear, carry_in, at_bound and carry_out; instantiated NUM_LEVELS times in a generate loop, carry chained level 0 → NUM_LEVELS-1.

## Test plan
- bound={3,2,1} (level2..0), idx_ready=1 → 24 consecutive beats, idx sequence (0,0,0),(0,0,1),(0,1,0)…(3,2,1); last on beat 24 only; done one cycle after.
- Same run, idx_ready toggled 1/0 each cycle → identical sequence, held values during stalls, 24 acceptances; with macro, stall_cnt=23.
- All bounds 0, start → exactly one beat idx=(0,0,0) with wrap=3'b111, last=1; done next cycle.
- bound={1,1,1}, abort after 3rd acceptance → idx_valid=0 next cycle, no done; new start replays from (0,0,0).
- start pulsed while busy, and bound changed mid-run → run continues unchanged with originally latched bounds.
- Reset asserted mid-run → all outputs 0 asynchronously; after release, idle until start.

Source files
------------

// File: rtl/gnn_cnt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gnn_cnt_pkg
//  Purpose  : Shared types and constants for the nested-loop index generator
//             (FSM state encoding, default index vector type, stall-counter
//             width).
//  Revision : 1.0  initial release
// ============================================================================
package gnn_cnt_pkg;

    // Default per-level index width; the top module may override CNT_W.
    localparam int CNT_W_DEFAULT = 8;

    // Width of the optional stall cycle counter.
    localparam int STALL_CNT_W = 32;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One level's index / bound value at the default width.
    typedef logic [CNT_W_DEFAULT-1:0] cnt_idx_t;

endpackage
`default_nettype wire

// File: rtl/loop_level.sv
`default_nettype none
// ============================================================================
//  Module   : loop_level
//  Purpose  : One level of the loop nest. Holds a runtime bound (inclusive
//             last index) and an index that advances on carry_in, wrapping
//             to zero at the bound and passing the carry onward.
//  Revision : 1.0  initial release
// ============================================================================
module loop_level #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic             carry_in,
    input  logic [CNT_W-1:0] bound_in,
    output logic [CNT_W-1:0] idx,
    output logic             at_bound,
    output logic             carry_out
);

    logic [CNT_W-1:0] r_bound;
    logic [CNT_W-1:0] r_idx;

    // Bound and index registers: load latches a new bound and restarts the
    // index, clear restarts only the index, carry_in advances or wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bound <= '0;
            r_idx   <= '0;
        end else if (load) begin
            r_bound <= bound_in;
            r_idx   <= '0;
        end else if (clear) begin
            r_idx   <= '0;
        end else if (carry_in) begin
            r_idx   <= at_bound ? '0 : (r_idx + {{(CNT_W-1){1'b0}}, 1'b1});
        end
    end

    // The index never passes the bound, so equality is the wrap condition.
    assign at_bound  = (r_idx == r_bound);
    assign carry_out = carry_in && at_bound;
    assign idx       = r_idx;

endmodule
`default_nettype wire

// File: rtl/loop_nest_counter.sv
`default_nettype none
// ============================================================================
//  Module   : loop_nest_counter
//  Purpose  : NUM_LEVELS cascaded wrap counters (level 0 innermost) with
//             per-run latched bounds, start/abort/done control and a
//             valid/ready index-tuple output.
//  Options  : LOOP_NEST_STALL_CNT_EN - adds a saturating 32-bit stall_cnt
//             output counting RUN cycles where the beat is not accepted.
//  Revision : 1.0  initial release
// ============================================================================
module loop_nest_counter
    import gnn_cnt_pkg::*;
#(
    parameter int NUM_LEVELS = 3,
    parameter int CNT_W      = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [NUM_LEVELS*CNT_W-1:0] bound,
    input  logic                        idx_ready,
    output logic [NUM_LEVELS*CNT_W-1:0] idx,
    output logic                        idx_valid,
    output logic [NUM_LEVELS-1:0]       wrap,
    output logic                        last,
    output logic                        busy,
    output logic                        done
`ifdef LOOP_NEST_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0]      stall_cnt
`endif
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_run;
    logic                  w_start_acc;
    logic                  w_accept;
    logic                  w_clear;
    logic                  w_final;
    logic [NUM_LEVELS-1:0] w_at_bound;
    logic [NUM_LEVELS-1:0] w_wrap_pre;

    assign w_run       = (r_state == ST_RUN);
    // A start is taken outside RUN only, and abort always suppresses it.
    assign w_start_acc = start && !abort && !w_run;
    // Abort outranks acceptance of the current beat.
    assign w_accept    = w_run && idx_ready && !abort;
    assign w_clear     = w_run && abort;

    // Level chain: level 0 steps on every accepted beat, each higher level
    // steps on the carry out of the level below it.
    for (genvar k = 0; k < NUM_LEVELS; k++) begin : g_level
        logic w_cin;
        logic w_cout;

        if (k == 0) begin : g_head
            assign w_cin = w_accept;
        end else begin : g_chain
            assign w_cin = g_level[k-1].w_cout;
        end

        loop_level #(
            .CNT_W (CNT_W)
        ) u_level (
            .clk       (clk),
            .reset     (reset),
            .load      (w_start_acc),
            .clear     (w_clear),
            .carry_in  (w_cin),
            .bound_in  (bound[k*CNT_W +: CNT_W]),
            .idx       (idx[k*CNT_W +: CNT_W]),
            .at_bound  (w_at_bound[k]),
            .carry_out (w_cout)
        );

        // Level k wraps when it and every faster level sit at their bounds.
        assign w_wrap_pre[k] = &w_at_bound[k:0];
    end

    // Carry out of the outermost level marks acceptance of the final beat.
    assign w_final = g_level[NUM_LEVELS-1].w_cout;

    // wrap/last depend only on registered state, never on idx_ready.
    assign wrap = w_run ? w_wrap_pre : '0;
    assign last = &wrap;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        idx_valid   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_acc) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                idx_valid = 1'b1;
                busy      = 1'b1;
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_final) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = w_start_acc ? ST_RUN : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef LOOP_NEST_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Saturating count of RUN cycles with a valid beat held back by the sink.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_start_acc) begin
            r_stall_cnt <= '0;
        end else if (w_run && !idx_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_loop_nest_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_loop_nest_counter
//  Purpose  : Self-checking bench for loop_nest_counter (3 levels x 8 bits).
//             Honours LOOP_NEST_STALL_CNT_EN when defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_loop_nest_counter;

    localparam int NL = 3;
    localparam int CW = 8;

    logic              clk;
    logic              reset;
    logic              start;
    logic              abort;
    logic [NL*CW-1:0]  bound;
    logic              idx_ready;
    logic [NL*CW-1:0]  idx;
    logic              idx_valid;
    logic [NL-1:0]     wrap;
    logic              last;
    logic              busy;
    logic              done;
`ifdef LOOP_NEST_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    int tests;
    int fails;

    loop_nest_counter #(
        .NUM_LEVELS (NL),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .bound     (bound),
        .idx_ready (idx_ready),
        .idx       (idx),
        .idx_valid (idx_valid),
        .wrap      (wrap),
        .last      (last),
        .busy      (busy),
        .done      (done)
`ifdef LOOP_NEST_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if something hangs.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic             start;
        logic             abort;
        logic             ready;
        logic [NL*CW-1:0] bound;
        logic [NL*CW-1:0] e_idx;
        logic             e_valid;
        logic [NL-1:0]    e_wrap;
        logic             e_last;
        logic             e_busy;
        logic             e_done;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare the full observable output set {idx, valid, wrap, last, busy, done}.
    task automatic check_out(input string name, input logic [NL*CW-1:0] e_idx,
                             input logic e_valid, input logic [NL-1:0] e_wrap,
                             input logic e_last, input logic e_busy, input logic e_done);
        check(name, 64'({idx, idx_valid, wrap, last, busy, done}),
                    64'({e_idx, e_valid, e_wrap, e_last, e_busy, e_done}));
    endtask

    // Expected tuple for beat b of a run with bounds {b2,b1,b0}.
    function automatic logic [NL*CW-1:0] tup(input int b, input int b0, input int b1);
        int i0, i1, i2;
        i0 = b % (b0 + 1);
        i1 = (b / (b0 + 1)) % (b1 + 1);
        i2 = b / ((b0 + 1) * (b1 + 1));
        return {8'(i2), 8'(i1), 8'(i0)};
    endfunction

    function automatic logic [NL-1:0] exp_wrap(input int b, input int b0, input int b1, input int b2);
        int i0, i1, i2;
        logic w0, w1, w2;
        i0 = b % (b0 + 1);
        i1 = (b / (b0 + 1)) % (b1 + 1);
        i2 = b / ((b0 + 1) * (b1 + 1));
        w0 = (i0 == b0);
        w1 = w0 && (i1 == b1);
        w2 = w1 && (i2 == b2);
        return {w2, w1, w0};
    endfunction

    initial begin
        int beat;
        int cyc;

        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        bound     = '0;
        idx_ready = 1'b0;

        // ---------------- vector table: single-beat run, abort, suppressed start
        //            start  abort  ready  bound       e_idx       vld   wrap    last  busy  done
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 24'h000000, 24'h000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 24'h000000, 24'h000000, 1'b1, 3'b111, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 24'h000000, 24'h000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 24'h000000, 24'h000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 24'h010101, 24'h000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 24'h010101, 24'h000000, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 24'h010101, 24'h000001, 1'b1, 3'b001, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 24'h010101, 24'h000100, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 24'h010101, 24'h000101, 1'b1, 3'b011, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 24'h010101, 24'h000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 24'h010101, 24'h000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 24'h010101, 24'h000000, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 24'h010101, 24'h000001, 1'b1, 3'b001, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 24'h010101, 24'h000100, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 24'h010101, 24'h000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 24'h010101, 24'h000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 24'h010101, 24'h000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0};

        // ---------------- reset state
        repeat (2) @(negedge clk);
        #1 check_out("reset_state", 24'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1 check_out("after_reset_idle", 24'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);

        // ---------------- table-driven vectors
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            start     = vecs[i].start;
            abort     = vecs[i].abort;
            idx_ready = vecs[i].ready;
            bound     = vecs[i].bound;
            #1 check_out($sformatf("vec%0d", i), vecs[i].e_idx, vecs[i].e_valid,
                         vecs[i].e_wrap, vecs[i].e_last, vecs[i].e_busy, vecs[i].e_done);
        end

        // ---------------- A: bound {3,2,1}, ready high, start + bound change mid-run
        @(negedge clk);
        start = 1'b1; abort = 1'b0; idx_ready = 1'b1; bound = 24'h030201;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 24; b++) begin
            #1;
            check($sformatf("A_idx%0d", b), 64'(idx), 64'(tup(b, 1, 2)));
            check($sformatf("A_flags%0d", b), 64'({idx_valid, busy, wrap, last}),
                  64'({1'b1, 1'b1, exp_wrap(b, 1, 2, 3), (b == 23)}));
            if (b == 5) begin
                start = 1'b1;
                bound = 24'h000000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        #1 check_out("A_done", 24'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1 check_out("A_idle", 24'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);

        // ---------------- B: same run with idx_ready toggling 1/0
        @(negedge clk);
        start = 1'b1; bound = 24'h030201; idx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        beat  = 0;
        cyc   = 0;
        while (beat < 24 && cyc < 200) begin
            idx_ready = (cyc % 2 == 0);
            #1 check($sformatf("B_idx_c%0d", cyc), 64'({idx_valid, idx}), 64'({1'b1, tup(beat, 1, 2)}));
            if (idx_ready) beat++;
            @(negedge clk);
            cyc++;
        end
        check("B_acceptances", 64'(beat), 64'(24));
        idx_ready = 1'b1;
        #1 check_out("B_done", 24'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
`ifdef LOOP_NEST_STALL_CNT_EN
        check("B_stall_cnt", 64'(stall_cnt), 64'(23));
`endif
        @(negedge clk);

        // ---------------- C: asynchronous reset mid-run
        @(negedge clk);
        start = 1'b1; bound = 24'h030201; idx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("C_pre_reset_idx", 64'(idx), 64'(tup(3, 1, 2)));
        #1 reset = 1'b1;
        #1 check_out("C_async_reset", 24'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
`ifdef LOOP_NEST_STALL_CNT_EN
        check("C_stall_reset", 64'(stall_cnt), 64'(0));
`endif
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check_out($sformatf("C_idle%0d", i), 24'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
